// File: rtl/mem_bank_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank_timing_pkg
// Brief    : Command codes, bank states and sizing helpers for mem_bank_timing
// Revision : 1.0
// ============================================================================
package mem_bank_timing_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PR  = 3'd4,
        CMD_PRA = 3'd5,
        CMD_REF = 3'd6
    } cmd_e;

    typedef enum logic [1:0] {
        BANK_IDLE        = 2'd0,
        BANK_ACTIVATING  = 2'd1,
        BANK_ACTIVE      = 2'd2,
        BANK_PRECHARGING = 2'd3
    } bank_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bank_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank_fsm
// Brief    : One bank's open/close state machine with ACT and PR timing
// Revision : 1.0
// ============================================================================
module mem_bank_fsm
    import mem_bank_timing_pkg::*;
#(
    parameter int ROW_W = 7,
    parameter int TRCD  = 3,
    parameter int TRP   = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_halt,
    input  logic             i_act,
    input  logic             i_pre,
    input  logic [ROW_W-1:0] i_act_row,
    output bank_state_e      o_state,
    output logic [ROW_W-1:0] o_open_row,
    output logic             o_is_open
);

    bank_state_e      r_state;
    bank_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [ROW_W-1:0] r_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BANK_IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
        end else if (!i_halt) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (i_act && r_state == BANK_IDLE) begin
                r_row <= i_act_row;
            end
        end
    end

    // Timed states load T-1 so the target state is visible T cycles after accept.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            BANK_IDLE: begin
                if (i_act) begin
                    if (TRCD > 1) begin
                        w_state_nxt = BANK_ACTIVATING;
                        w_cnt_nxt   = CNT_W'(TRCD - 1);
                    end else begin
                        w_state_nxt = BANK_ACTIVE;
                    end
                end
            end
            BANK_ACTIVATING: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = BANK_ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            BANK_ACTIVE: begin
                if (i_pre) begin
                    if (TRP > 1) begin
                        w_state_nxt = BANK_PRECHARGING;
                        w_cnt_nxt   = CNT_W'(TRP - 1);
                    end else begin
                        w_state_nxt = BANK_IDLE;
                    end
                end
            end
            BANK_PRECHARGING: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = BANK_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = BANK_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        o_state    = r_state;
        o_open_row = r_row;
        o_is_open  = (r_state == BANK_ACTIVE);
    end

endmodule
`default_nettype wire

// File: rtl/sram.sv
`default_nettype none
// ============================================================================
// Module   : sram
// Brief    : Single-port storage, synchronous write, combinational read
// Revision : 1.0
// ============================================================================
module sram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32768,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset so data survives a controller reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/mem_bank_timing.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank_timing
// Brief    : Multi-bank memory controller enforcing ACT/PR/REF/CL timing
// Revision : 1.0
// ============================================================================
module mem_bank_timing
    import mem_bank_timing_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int BANKS   = 4,
    parameter int ROWS    = 128,
    parameter int COLUMNS = 64,
    parameter int TRCD    = 3,
    parameter int TRP     = 3,
    parameter int TCL     = 2,
    parameter int TRFC    = 8,
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int ROW_W  = $clog2(ROWS),
    localparam int COL_W  = $clog2(COLUMNS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd,
    input  logic [BANK_W-1:0] bank,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  column,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              cmd_ready,
    output logic              cmd_err,
    output logic [BANKS-1:0]  bank_open
);

    localparam int CNT_W  = $clog2(max3(TRCD, TRP, TRFC) + 1);
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int DEPTH  = BANKS * ROWS * COLUMNS;

    bank_state_e      w_bank_state [BANKS];
    logic [ROW_W-1:0] w_open_row   [BANKS];
    logic [BANKS-1:0] w_act;
    logic [BANKS-1:0] w_pre;
    logic [BANKS-1:0] w_is_open;
    bank_state_e      w_sel_state;
    logic             w_accept;
    logic             w_legal;
    logic             w_bank_ok;
    logic             w_any_busy;
    logic             w_all_idle;
    logic             w_do_rd;
    logic             w_do_wr;
    logic             w_do_ref;
    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH-1:0]  w_rdata;

    logic             r_refreshing;
    logic [CNT_W-1:0] r_ref_cnt;
    logic             r_cmd_err;
    logic [TCL-1:0]   r_pipe_valid;
    logic [WIDTH-1:0] r_pipe_data [TCL];

    assign w_accept    = cmd_valid & ~halt;
    assign w_bank_ok   = (int'(bank) < BANKS);
    assign w_sel_state = w_bank_ok ? w_bank_state[bank] : BANK_IDLE;

    always_comb begin
        w_any_busy = 1'b0;
        w_all_idle = 1'b1;
        for (int b = 0; b < BANKS; b++) begin
            if (w_bank_state[b] == BANK_ACTIVATING || w_bank_state[b] == BANK_PRECHARGING) begin
                w_any_busy = 1'b1;
            end
            if (w_bank_state[b] != BANK_IDLE) begin
                w_all_idle = 1'b0;
            end
        end
    end

    // While refreshing every bank is blocked, so only NOP is legal.
    always_comb begin
        w_legal = 1'b0;
        case (cmd)
            CMD_NOP: w_legal = 1'b1;
            CMD_ACT: w_legal = !r_refreshing && w_bank_ok && (w_sel_state == BANK_IDLE);
            CMD_RD,
            CMD_WR:  w_legal = !r_refreshing && w_bank_ok && (w_sel_state == BANK_ACTIVE);
            CMD_PR:  w_legal = !r_refreshing && w_bank_ok &&
                               (w_sel_state == BANK_ACTIVE || w_sel_state == BANK_IDLE);
            CMD_PRA: w_legal = !r_refreshing && !w_any_busy;
            CMD_REF: w_legal = !r_refreshing && w_all_idle;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_do_rd  = w_accept & w_legal & (cmd == CMD_RD);
    assign w_do_wr  = w_accept & w_legal & (cmd == CMD_WR);
    assign w_do_ref = w_accept & w_legal & (cmd == CMD_REF);

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        assign w_act[b] = w_accept & w_legal & (cmd == CMD_ACT) & (bank == BANK_W'(b));
        assign w_pre[b] = w_accept & w_legal &
                          (((cmd == CMD_PR) & (bank == BANK_W'(b))) | (cmd == CMD_PRA));

        mem_bank_fsm #(
            .ROW_W (ROW_W),
            .TRCD  (TRCD),
            .TRP   (TRP),
            .CNT_W (CNT_W)
        ) u_bank_fsm (
            .clk        (clk),
            .rst        (rst),
            .i_halt     (halt),
            .i_act      (w_act[b]),
            .i_pre      (w_pre[b]),
            .i_act_row  (row),
            .o_state    (w_bank_state[b]),
            .o_open_row (w_open_row[b]),
            .o_is_open  (w_is_open[b])
        );
    end

    // Column accesses use the row latched at ACT; the row input is ignored here.
    assign w_addr = {bank, w_open_row[bank], column};

    sram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_do_wr),
        .i_addr  (w_addr),
        .i_wdata (wr_data),
        .o_rdata (w_rdata)
    );

    // REF loads the full TRFC so banks stay blocked TRFC cycles after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refreshing <= 1'b0;
            r_ref_cnt    <= '0;
        end else if (!halt) begin
            if (w_do_ref) begin
                r_refreshing <= 1'b1;
                r_ref_cnt    <= CNT_W'(TRFC);
            end else if (r_refreshing) begin
                if (r_ref_cnt <= CNT_W'(1)) begin
                    r_refreshing <= 1'b0;
                    r_ref_cnt    <= '0;
                end else begin
                    r_ref_cnt <= r_ref_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_accept & ~w_legal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_valid <= '0;
            for (int i = 0; i < TCL; i++) begin
                r_pipe_data[i] <= '0;
            end
        end else if (!halt) begin
            r_pipe_valid[0] <= w_do_rd;
            if (w_do_rd) begin
                r_pipe_data[0] <= w_rdata;
            end
            for (int i = 1; i < TCL; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_data[i]  <= r_pipe_data[i-1];
            end
        end
    end

    assign rd_valid  = r_pipe_valid[TCL-1] & ~halt;
    assign rd_data   = r_pipe_data[TCL-1];
    assign cmd_ready = ~halt;
    assign cmd_err   = r_cmd_err;
    assign bank_open = w_is_open;

endmodule
`default_nettype wire
